// File: rtl/iob_interval_timer_ctrl_if.sv
// Configuration/command and status bundle between the CSR block and the
// interval timer controller.
interface iob_interval_timer_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int EVT_W  = 8
);
    logic [DATA_W-1:0] period_i;
    logic              periodic_i;
    logic              start_i;
    logic              stop_i;
    logic              pause_i;
    logic              evt_clr_i;
    logic              busy_o;
    logic              done_o;
    logic              tick_o;
    logic              err_o;
    logic [DATA_W-1:0] count_o;
    logic [EVT_W-1:0]  evt_cnt_o;

    // CSR side: drives configuration and commands, observes status
    modport master (
        output period_i, periodic_i, start_i, stop_i, pause_i, evt_clr_i,
        input  busy_o, done_o, tick_o, err_o, count_o, evt_cnt_o
    );

    // Timer side: consumes configuration and commands, produces status
    modport slave (
        input  period_i, periodic_i, start_i, stop_i, pause_i, evt_clr_i,
        output busy_o, done_o, tick_o, err_o, count_o, evt_cnt_o
    );
endinterface

// File: rtl/iob_interval_timer_ctrl.sv
// Programmable interval timer controller: sequences an internal loadable
// up-counter for one-shot or periodic expiry, with pause, restart, abort and
// a saturating expiry-event counter. cke_i low freezes every register.
module iob_interval_timer_ctrl #(
    parameter int DATA_W = 32,
    parameter int EVT_W  = 8
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic rst_i,
    iob_interval_timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_period;
    logic              r_periodic;
    logic [DATA_W-1:0] r_count;
    logic [EVT_W-1:0]  r_evt_cnt;
    logic              r_tick;
    logic              r_err;

    logic              w_start_ok;
    logic              w_start_rej;
    logic              w_run_active;
    logic              w_expire;
    logic [DATA_W-1:0] w_period_m1;
    logic              w_cnt_load;
    logic              w_cnt_en;
    logic [DATA_W-1:0] w_cnt_load_val;
    logic              w_busy;
    logic              w_done;

    // Command decode: stop dominates start; a zero period start is rejected
    assign w_start_ok   = bus.start_i && !bus.stop_i && (bus.period_i != '0);
    assign w_start_rej  = bus.start_i && !bus.stop_i && (bus.period_i == '0);

    // Counting happens only in RUN, unpaused, and with no command overriding it
    assign w_run_active = (r_state == S_RUN) && !bus.pause_i && !bus.stop_i && !w_start_ok;

    // Reloading at P-1 keeps the count from ever wrapping, even for P = all-ones
    assign w_period_m1  = r_period - DATA_W'(1);
    assign w_expire     = w_run_active && (r_count == w_period_m1);

    // Counter controls: load zero on stop/start and on periodic expiry;
    // one-shot expiry leaves the count parked at P-1
    assign w_cnt_load     = bus.stop_i || w_start_ok || (w_expire && r_periodic);
    assign w_cnt_en       = w_run_active && !w_expire;
    assign w_cnt_load_val = '0;

    // State register
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop_i) begin
            w_state_nxt = S_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = S_RUN;
        end else if (w_expire && !r_periodic) begin
            w_state_nxt = S_DONE;
        end
    end

    // Output decode from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Loadable up-counter driven by the controller
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_count <= '0;
            end else if (w_cnt_load) begin
                r_count <= w_cnt_load_val;
            end else if (w_cnt_en) begin
                r_count <= r_count + DATA_W'(1);
            end
        end
    end

    // Latch period and mode on an accepted start (or restart)
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_period   <= '0;
                r_periodic <= 1'b0;
            end else if (w_start_ok) begin
                r_period   <= bus.period_i;
                r_periodic <= bus.periodic_i;
            end
        end
    end

    // Registered one-cycle tick and error pulses
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_tick <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                r_tick <= w_expire;
                r_err  <= w_start_rej;
            end
        end
    end

    // Saturating expiry-event counter; clear beats a coincident increment
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i || bus.evt_clr_i) begin
                r_evt_cnt <= '0;
            end else if (w_expire && (r_evt_cnt != '1)) begin
                r_evt_cnt <= r_evt_cnt + EVT_W'(1);
            end
        end
    end

    assign bus.busy_o    = w_busy;
    assign bus.done_o    = w_done;
    assign bus.tick_o    = r_tick;
    assign bus.err_o     = r_err;
    assign bus.count_o   = r_count;
    assign bus.evt_cnt_o = r_evt_cnt;

endmodule

// File: tb/tb_iob_interval_timer_ctrl.sv
// Scoreboard bench for iob_interval_timer_ctrl: directed scenarios followed by
// random commands, all predicted by a behavioural model and checked each cycle.
module tb_iob_interval_timer_ctrl;

    localparam int DW = 8;
    localparam int EW = 4;
    localparam int EVT_MAX = (1 << EW) - 1;

    logic clk_i;
    logic cke_i;
    logic rst_i;

    iob_interval_timer_ctrl_if #(.DATA_W(DW), .EVT_W(EW)) bus ();

    iob_interval_timer_ctrl #(.DATA_W(DW), .EVT_W(EW)) dut (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int cnt;
        int evt;
        bit tick;
        bit err;
        bit busy;
        bit done;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    // Model state: 0 idle, 1 running, 2 finished
    int m_state;
    int m_cnt;
    int m_per;
    bit m_perd;
    int m_evt;
    bit m_tick;
    bit m_err;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue expectation
    task automatic cyc(input bit st, input bit sp, input int per, input bit pd,
                       input bit ps, input bit cl, input bit ck, input bit rs);
        bit   expire;
        exp_t e;
        @(negedge clk_i);
        bus.start_i    = st;
        bus.stop_i     = sp;
        bus.period_i   = DW'(per);
        bus.periodic_i = pd;
        bus.pause_i    = ps;
        bus.evt_clr_i  = cl;
        cke_i          = ck;
        rst_i          = rs;
        if (ck) begin
            expire = 1'b0;
            m_err  = 1'b0;
            if (rs) begin
                m_state = 0; m_cnt = 0; m_per = 0; m_perd = 0; m_evt = 0;
            end else begin
                if (sp) begin
                    m_state = 0;
                    m_cnt   = 0;
                end else if (st && per != 0) begin
                    m_per   = per;
                    m_perd  = pd;
                    m_cnt   = 0;
                    m_state = 1;
                end else begin
                    if (st) m_err = 1'b1;
                    if (m_state == 1 && !ps) begin
                        if (m_cnt == m_per - 1) begin
                            expire = 1'b1;
                            if (m_perd) m_cnt = 0;
                            else        m_state = 2;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end
                end
                if (cl) m_evt = 0;
                else if (expire && m_evt < EVT_MAX) m_evt = m_evt + 1;
            end
            m_tick = expire;
        end
        e.cnt  = m_cnt;
        e.evt  = m_evt;
        e.tick = m_tick;
        e.err  = m_err;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic go(input int per, input bit pd);
        cyc(1, 0, per, pd, 0, 0, 1, 0);
    endtask

    // Monitor: the DUT presents status every cycle; compare after each edge
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("count_o",   int'(bus.count_o),   e.cnt);
            chk("evt_cnt_o", int'(bus.evt_cnt_o), e.evt);
            chk("tick_o",    int'(bus.tick_o),    int'(e.tick));
            chk("err_o",     int'(bus.err_o),     int'(e.err));
            chk("busy_o",    int'(bus.busy_o),    int'(e.busy));
            chk("done_o",    int'(bus.done_o),    int'(e.done));
        end
    end

    initial begin
        int wait_cyc;
        checks = 0; failures = 0;
        m_state = 0; m_cnt = 0; m_per = 0; m_perd = 0; m_evt = 0; m_tick = 0; m_err = 0;
        bus.start_i = 0; bus.stop_i = 0; bus.period_i = '0; bus.periodic_i = 0;
        bus.pause_i = 0; bus.evt_clr_i = 0; cke_i = 1; rst_i = 1;

        // Reset
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Periodic P=4
        go(4, 1);
        idle(14);

        // One-shot P=3, then long idle in DONE with pause toggling
        go(3, 0);
        idle(5);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, i[0], 0, 1, 0);

        // Periodic P=5, pause at count 2 for 3 cycles, then restart with P=2
        go(5, 1);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 1, 0);
        idle(9);
        go(2, 1);
        idle(6);

        // Rejected start, start+stop together, stop mid-run
        cyc(1, 0, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 7, 1, 0, 0, 1, 0);
        idle(3);
        go(6, 1);
        idle(5);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        idle(8);

        // P=1 periodic: saturation, then clear coincident with expiry
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        go(1, 1);
        idle(EVT_MAX + 4);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        idle(3);

        // Clock enable low mid-run with tick high, then reset mid-run
        for (int i = 0; i < 4; i++) cyc(1, 1, 3, 0, 1, 1, 0, 1);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Maximum period, one-shot
        go((1 << DW) - 1, 0);
        idle((1 << DW) + 4);

        // Random commands
        for (int i = 0; i < 3000; i++) begin
            bit st, sp, pd, ps, cl, ck, rs;
            int per;
            st  = ($urandom_range(0, 99) < 6);
            sp  = ($urandom_range(0, 99) < 2);
            per = $urandom_range(0, 9);
            pd  = $urandom_range(0, 1);
            ps  = ($urandom_range(0, 99) < 20);
            cl  = ($urandom_range(0, 99) < 3);
            ck  = ($urandom_range(0, 99) < 90);
            rs  = ($urandom_range(0, 999) < 5);
            cyc(st, sp, per, pd, ps, cl, ck, rs);
        end
        idle(2);

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk_i);
            wait_cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
